// File: rtl/pipelined_ctrl_unit.sv
// pipelined_ctrl_unit
//   Registered ID->EX control decode for the MIPS-subset pipeline. One 32-bit
//   instruction is decoded per cycle into the *_EX control fields, one cycle
//   of latency. A down-counter tracks how long HI/LO stay busy after a
//   mult/multu enters EX, and ID is stalled when it holds another HI/LO user.
//
//   Optional feature macro: CTRL_BRANCH_EN
//     defined   : beq/bne decode as SUB compares, pc_src_EX/flush_ID resolve
//                 the branch in EX and squash the instruction in ID.
//     undefined : zero_EX, pc_src_EX and flush_ID do not exist and
//                 beq/bne are reported as illegal.
module pipelined_ctrl_unit #(
  parameter int ALU_OP_W    = 4,
  parameter int SHAMT_W     = 5,
  parameter int MULT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  output logic                id_ready,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] alu_op_EX,
  output logic [SHAMT_W-1:0]  shamt_EX,
  output logic                enhilo_EX,
  output logic [1:0]          regsel_EX,
  output logic                regwrite_EX,
  output logic                rdrt_EX,
  output logic                memwrite_EX,
  output logic [1:0]          alu_src_EX,
  output logic                gpio_out_EX,
  output logic                gpio_in_EX,
  output logic                illegal_EX,
`ifdef CTRL_BRANCH_EN
  input  logic                zero_EX,
  output logic                pc_src_EX,
  output logic                flush_ID,
`endif
  output logic                hilo_busy
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_NOR   = 4'd2,
    ALU_XOR   = 4'd3,
    ALU_ADD   = 4'd4,
    ALU_SUB   = 4'd5,
    ALU_MULT  = 4'd6,
    ALU_MULTU = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_SLT   = 4'd12,
    ALU_SLTU  = 4'd13
  } alu_op_e;

  // Everything that is carried into the EX slot.
  typedef struct packed {
    logic       valid;
    alu_op_e    alu_op;
    logic [4:0] shamt;
    logic       enhilo;
    logic [1:0] regsel;
    logic       regwrite;
    logic       rdrt;
    logic [1:0] alu_src;
    logic       gpio_out;
    logic       gpio_in;
    logic       illegal;
  } ex_ctrl_t;

  // Decode result: EX fields plus the hazard classification used in ID.
  typedef struct packed {
    ex_ctrl_t ctrl;
    logic     is_mult;
    logic     uses_hilo;
  } dec_t;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       sh;
  dec_t             dec;
  ex_ctrl_t         ex_q;
  logic [CNT_W-1:0] hilo_cnt;
  logic             flush;
  logic             issue;

  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];
  assign sh     = id_instr[10:6];

  // Instruction decode of whatever currently sits in ID.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a value held (no latch).
    dec                = '0;
    dec.ctrl.valid     = 1'b1;
    if (id_instr == 32'h0) begin
      // Canonical NOP: a real instruction that controls nothing.
      dec.ctrl.valid   = 1'b1;
    end else if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21: begin dec.ctrl.alu_op = ALU_ADD;  dec.ctrl.regwrite = 1'b1; end
        6'h22, 6'h23: begin dec.ctrl.alu_op = ALU_SUB;  dec.ctrl.regwrite = 1'b1; end
        6'h24:        begin dec.ctrl.alu_op = ALU_AND;  dec.ctrl.regwrite = 1'b1; end
        6'h25:        begin dec.ctrl.alu_op = ALU_OR;   dec.ctrl.regwrite = 1'b1; end
        6'h26:        begin dec.ctrl.alu_op = ALU_XOR;  dec.ctrl.regwrite = 1'b1; end
        6'h27:        begin dec.ctrl.alu_op = ALU_NOR;  dec.ctrl.regwrite = 1'b1; end
        6'h2A:        begin dec.ctrl.alu_op = ALU_SLT;  dec.ctrl.regwrite = 1'b1; end
        6'h2B:        begin dec.ctrl.alu_op = ALU_SLTU; dec.ctrl.regwrite = 1'b1; end
        6'h00: begin
          dec.ctrl.alu_op   = ALU_SLL;
          dec.ctrl.shamt    = sh;
          dec.ctrl.regwrite = 1'b1;
        end
        6'h02: begin
          // srl by zero is repurposed as the GPIO output strobe.
          if (sh != 5'd0) begin
            dec.ctrl.alu_op   = ALU_SRL;
            dec.ctrl.shamt    = sh;
            dec.ctrl.regwrite = 1'b1;
          end else begin
            dec.ctrl.gpio_out = 1'b1;
          end
        end
        6'h03: begin
          // sra by zero is repurposed as a GPIO read into rd.
          if (sh != 5'd0) begin
            dec.ctrl.alu_op   = ALU_SRA;
            dec.ctrl.shamt    = sh;
            dec.ctrl.regwrite = 1'b1;
          end else begin
            dec.ctrl.gpio_in  = 1'b1;
            dec.ctrl.regsel   = 2'b11;
            dec.ctrl.regwrite = 1'b1;
          end
        end
        6'h18, 6'h19: begin
          dec.ctrl.alu_op = (funct[0]) ? ALU_MULTU : ALU_MULT;
          dec.ctrl.enhilo = 1'b1;
          dec.is_mult     = 1'b1;
          dec.uses_hilo   = 1'b1;
        end
        6'h10: begin dec.ctrl.regsel = 2'b01; dec.ctrl.regwrite = 1'b1; dec.uses_hilo = 1'b1; end
        6'h12: begin dec.ctrl.regsel = 2'b10; dec.ctrl.regwrite = 1'b1; dec.uses_hilo = 1'b1; end
        default: begin
          dec               = '0;
          dec.ctrl.illegal  = 1'b1;
        end
      endcase
    end else begin
      dec.ctrl.rdrt     = 1'b1;
      dec.ctrl.regwrite = 1'b1;
      case (opcode)
        6'h08, 6'h09: begin dec.ctrl.alu_op = ALU_ADD; dec.ctrl.alu_src = 2'b01; end
        6'h0A:        begin dec.ctrl.alu_op = ALU_SLT; dec.ctrl.alu_src = 2'b01; end
        6'h0C:        begin dec.ctrl.alu_op = ALU_AND; dec.ctrl.alu_src = 2'b10; end
        6'h0D:        begin dec.ctrl.alu_op = ALU_OR;  dec.ctrl.alu_src = 2'b10; end
        6'h0E:        begin dec.ctrl.alu_op = ALU_XOR; dec.ctrl.alu_src = 2'b10; end
        6'h0F: begin
          // lui is realised as imm << 16 through the shifter.
          dec.ctrl.alu_op  = ALU_SLL;
          dec.ctrl.shamt   = 5'd16;
          dec.ctrl.alu_src = 2'b10;
        end
`ifdef CTRL_BRANCH_EN
        6'h04, 6'h05: begin
          // Compare rs - rt; the ALU zero flag decides the branch in EX.
          dec.ctrl.alu_op   = ALU_SUB;
          dec.ctrl.rdrt     = 1'b0;
          dec.ctrl.regwrite = 1'b0;
        end
`endif
        default: begin
          dec               = '0;
          dec.ctrl.illegal  = 1'b1;
        end
      endcase
    end
  end

  // A HI/LO user in ID must wait while a multiply still owns HI/LO.
  assign hilo_busy = (hilo_cnt != '0);
  assign id_ready  = !(id_valid && hilo_busy && dec.uses_hilo);
  assign issue     = id_valid && id_ready && !flush;

  // EX slot register: decoded fields on issue, otherwise a bubble.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking (<=) for all flops so each one samples pre-edge values.
    if (!rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= issue ? dec.ctrl : '0;
    end
  end

  // HI/LO occupancy counter: reload on a multiply entering EX, then drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_cnt <= '0;
    end else if (issue && dec.is_mult) begin
      hilo_cnt <= CNT_W'(MULT_CYCLES);
    end else if (hilo_cnt != '0) begin
      hilo_cnt <= hilo_cnt - CNT_W'(1);
    end
  end

`ifdef CTRL_BRANCH_EN
  logic branch_EX;
  logic bne_EX;

  // Remember whether EX holds a beq/bne and which sense it tests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_EX <= 1'b0;
      bne_EX    <= 1'b0;
    end else begin
      branch_EX <= issue && (opcode[5:1] == 5'b00010);
      bne_EX    <= issue && (opcode == 6'h05);
    end
  end

  assign pc_src_EX = branch_EX && (zero_EX ^ bne_EX);
  assign flush_ID  = pc_src_EX;
  assign flush     = pc_src_EX;
`else
  assign flush     = 1'b0;
`endif

  assign ex_valid    = ex_q.valid;
  assign alu_op_EX   = ALU_OP_W'(ex_q.alu_op);
  assign shamt_EX    = SHAMT_W'(ex_q.shamt);
  assign enhilo_EX   = ex_q.enhilo;
  assign regsel_EX   = ex_q.regsel;
  assign regwrite_EX = ex_q.regwrite;
  assign rdrt_EX     = ex_q.rdrt;
  assign memwrite_EX = 1'b0;
  assign alu_src_EX  = ex_q.alu_src;
  assign gpio_out_EX = ex_q.gpio_out;
  assign gpio_in_EX  = ex_q.gpio_in;
  assign illegal_EX  = ex_q.illegal;

endmodule
